// File: rtl/m2_phase_scheduler_pkg.sv
// Shared types and constants for the Milestone 2 IDCT phase scheduler.
package m2_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FS_LI,
        S_CT_LI,
        S_MEGA_A,
        S_MEGA_B,
        S_CS_LO,
        S_WS_LO
    } m2_sched_state_type;

    typedef enum logic [1:0] {
        SEG_Y,
        SEG_U,
        SEG_V
    } seg_type;

    typedef struct packed {
        seg_type    seg;
        logic [4:0] row;
        logic [5:0] col;
    } cursor_type;

    localparam logic [17:0] WS_Y_BASE = 18'd0;
    localparam logic [17:0] WS_U_BASE = 18'd38400;
    localparam logic [17:0] WS_V_BASE = 18'd57600;
    localparam logic [17:0] FS_Y_BASE = 18'd76800;
    localparam logic [17:0] FS_U_BASE = 18'd153600;
    localparam logic [17:0] FS_V_BASE = 18'd192000;

    localparam logic [8:0] STRIDE_320 = 9'd320;
    localparam logic [8:0] STRIDE_160 = 9'd160;
    localparam logic [8:0] STRIDE_80  = 9'd80;

    localparam int Y_BLOCKS     = 1200;
    localparam int UV_BLOCKS    = 600;
    localparam int TOTAL_BLOCKS = 2400;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_FS   = 2'd1;
    localparam logic [1:0] OWNER_WS   = 2'd2;

    localparam cursor_type CURSOR_ORIGIN = '{seg: SEG_Y, row: 5'd0, col: 6'd0};

    // Raster step: column wraps at the segment width, row wraps at the segment height.
    function automatic cursor_type next_cursor(input cursor_type c, input int y_cols,
                                               input int uv_cols, input int rows);
        cursor_type n;
        logic [5:0] last_col;
        n = c;
        last_col = (c.seg == SEG_Y) ? 6'(y_cols - 1) : 6'(uv_cols - 1);
        if (c.col != last_col) begin
            n.col = c.col + 6'd1;
        end else begin
            n.col = 6'd0;
            if (c.row != 5'(rows - 1)) begin
                n.row = c.row + 5'd1;
            end else begin
                n.row = 5'd0;
                n.seg = (c.seg == SEG_Y) ? SEG_U : SEG_V;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/m2_phase_scheduler_block_addr.sv
// Maps a block cursor to its SRAM base address and row stride using shifts and adds.
module m2_block_addr
    import m2_sched_pkg::*;
#(
    parameter bit IS_WRITE = 1'b0,
    parameter int STRIDE_W = 9
) (
    input  seg_type             seg,
    input  logic [4:0]          row,
    input  logic [5:0]          col,
    output logic [17:0]         base,
    output logic [STRIDE_W-1:0] stride
);

    logic [17:0] r;
    logic [17:0] c;
    logic [17:0] seg_base;
    logic [17:0] row_term;
    logic [17:0] col_term;
    logic [8:0]  full_stride;

    assign r = 18'(row);
    assign c = 18'(col);

    // Fetch rows are 2560/1280 words apart, write rows 1280/640 (Y vs U/V).
    always_comb begin
        seg_base    = 18'd0;
        row_term    = 18'd0;
        full_stride = 9'd0;
        col_term    = IS_WRITE ? (c << 2) : (c << 3);
        if (IS_WRITE) begin
            case (seg)
                SEG_Y: begin
                    seg_base    = WS_Y_BASE;
                    row_term    = (r << 10) + (r << 8);
                    full_stride = STRIDE_160;
                end
                SEG_U: begin
                    seg_base    = WS_U_BASE;
                    row_term    = (r << 9) + (r << 7);
                    full_stride = STRIDE_80;
                end
                default: begin
                    seg_base    = WS_V_BASE;
                    row_term    = (r << 9) + (r << 7);
                    full_stride = STRIDE_80;
                end
            endcase
        end else begin
            case (seg)
                SEG_Y: begin
                    seg_base    = FS_Y_BASE;
                    row_term    = (r << 11) + (r << 9);
                    full_stride = STRIDE_320;
                end
                SEG_U: begin
                    seg_base    = FS_U_BASE;
                    row_term    = (r << 10) + (r << 8);
                    full_stride = STRIDE_160;
                end
                default: begin
                    seg_base    = FS_V_BASE;
                    row_term    = (r << 10) + (r << 8);
                    full_stride = STRIDE_160;
                end
            endcase
        end
    end

    assign base   = seg_base + row_term + col_term;
    assign stride = STRIDE_W'(full_stride);

endmodule

// File: rtl/m2_phase_scheduler.sv
// Milestone 2 top-level sequencer: walks Y/U/V blocks and overlaps FS with CS and CT with WS.
module m2_phase_scheduler
    import m2_sched_pkg::*;
#(
    parameter int Y_BLOCK_COLS  = 40,
    parameter int UV_BLOCK_COLS = 20,
    parameter int BLOCK_ROWS    = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        fs_start,
    output logic        ct_start,
    output logic        cs_start,
    output logic        ws_start,
    input  logic        fs_done,
    input  logic        ct_done,
    input  logic        cs_done,
    input  logic        ws_done,
    output logic [17:0] fs_base_address,
    output logic [8:0]  fs_row_stride,
    output logic [17:0] ws_base_address,
    output logic [7:0]  ws_row_stride,
    output logic [1:0]  sram_owner
);

    // The write cursor of the last overlapped pair trails the final block by one.
    localparam cursor_type LAST_W = '{seg: SEG_V, row: 5'(BLOCK_ROWS - 1), col: 6'(UV_BLOCK_COLS - 2)};

    m2_sched_state_type state, nxt_state;
    cursor_type  f_cur, w_cur, f_sel, w_sel, f_adv;
    logic        fs_flag, ct_flag, cs_flag, ws_flag;
    logic        fs_ok, ct_ok, cs_ok, ws_ok, advance;
    logic [17:0] f_base, w_base;
    logic [8:0]  f_stride;
    logic [7:0]  w_stride;

    assign f_adv   = next_cursor(f_cur, Y_BLOCK_COLS, UV_BLOCK_COLS, BLOCK_ROWS);
    assign fs_ok   = fs_flag | (fs_done & ~fs_start);
    assign ct_ok   = ct_flag | (ct_done & ~ct_start);
    assign cs_ok   = cs_flag | (cs_done & ~cs_start);
    assign ws_ok   = ws_flag | (ws_done & ~ws_start);
    assign advance = (nxt_state != state);

    m2_block_addr #(.IS_WRITE(1'b0), .STRIDE_W(9)) u_fetch_addr (
        .seg(f_sel.seg), .row(f_sel.row), .col(f_sel.col), .base(f_base), .stride(f_stride)
    );

    m2_block_addr #(.IS_WRITE(1'b1), .STRIDE_W(8)) u_write_addr (
        .seg(w_sel.seg), .row(w_sel.row), .col(w_sel.col), .base(w_base), .stride(w_stride)
    );

    // Next phase and the cursor values that phase will work on.
    always_comb begin
        nxt_state = state;
        f_sel     = f_cur;
        w_sel     = w_cur;
        case (state)
            S_IDLE: if (start) begin
                nxt_state = S_FS_LI;
                f_sel     = CURSOR_ORIGIN;
            end
            S_FS_LI:  if (fs_ok) nxt_state = S_CT_LI;
            S_CT_LI: if (ct_ok) begin
                nxt_state = S_MEGA_A;
                w_sel     = f_cur;
                f_sel     = f_adv;
            end
            S_MEGA_A: if (fs_ok && cs_ok) nxt_state = S_MEGA_B;
            S_MEGA_B: if (ct_ok && ws_ok) begin
                if (w_cur != LAST_W) begin
                    nxt_state = S_MEGA_A;
                    w_sel     = f_cur;
                    f_sel     = f_adv;
                end else begin
                    nxt_state = S_CS_LO;
                end
            end
            S_CS_LO: if (cs_ok) begin
                nxt_state = S_WS_LO;
                w_sel     = f_cur;
            end
            S_WS_LO: if (ws_ok) nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Start pulses, addresses and SRAM ownership are all loaded on phase entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            f_cur           <= CURSOR_ORIGIN;
            w_cur           <= CURSOR_ORIGIN;
            {fs_flag, ct_flag, cs_flag, ws_flag}     <= 4'b0;
            {fs_start, ct_start, cs_start, ws_start} <= 4'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            fs_base_address <= 18'd0;
            fs_row_stride   <= 9'd0;
            ws_base_address <= 18'd0;
            ws_row_stride   <= 8'd0;
            sram_owner      <= OWNER_NONE;
        end else begin
            state <= nxt_state;
            f_cur <= f_sel;
            w_cur <= w_sel;
            {fs_start, ct_start, cs_start, ws_start} <= 4'b0;
            done  <= 1'b0;
            if (advance) begin
                {fs_flag, ct_flag, cs_flag, ws_flag} <= 4'b0;
            end else if (state == S_MEGA_A) begin
                fs_flag <= fs_ok;
                cs_flag <= cs_ok;
            end else if (state == S_MEGA_B) begin
                ct_flag <= ct_ok;
                ws_flag <= ws_ok;
            end
            if (advance) begin
                case (nxt_state)
                    S_FS_LI: begin
                        fs_start        <= 1'b1;
                        fs_base_address <= f_base;
                        fs_row_stride   <= f_stride;
                        busy            <= 1'b1;
                        sram_owner      <= OWNER_FS;
                    end
                    S_CT_LI: begin
                        ct_start   <= 1'b1;
                        sram_owner <= OWNER_NONE;
                    end
                    S_MEGA_A: begin
                        cs_start        <= 1'b1;
                        fs_start        <= 1'b1;
                        fs_base_address <= f_base;
                        fs_row_stride   <= f_stride;
                        sram_owner      <= OWNER_FS;
                    end
                    S_MEGA_B: begin
                        ct_start        <= 1'b1;
                        ws_start        <= 1'b1;
                        ws_base_address <= w_base;
                        ws_row_stride   <= w_stride;
                        sram_owner      <= OWNER_WS;
                    end
                    S_CS_LO: begin
                        cs_start   <= 1'b1;
                        sram_owner <= OWNER_NONE;
                    end
                    S_WS_LO: begin
                        ws_start        <= 1'b1;
                        ws_base_address <= w_base;
                        ws_row_stride   <= w_stride;
                        sram_owner      <= OWNER_WS;
                    end
                    default: begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        sram_owner <= OWNER_NONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_m2_phase_scheduler.sv
// Bench for m2_phase_scheduler: random-latency engine responders against a phase-list model.
module tb_m2_phase_scheduler;

    logic        clk = 1'b0;
    logic        reset, start;
    logic        busy, done;
    logic        fs_start, ct_start, cs_start, ws_start;
    logic        fs_done, ct_done, cs_done, ws_done;
    logic [17:0] fs_base_address, ws_base_address;
    logic [8:0]  fs_row_stride;
    logic [7:0]  ws_row_stride;
    logic [1:0]  sram_owner;

    logic [3:0]  resp_done;
    logic        extra_ws;
    logic [3:0]  eng_active, fin, st, nd;
    int          age [4];
    int          dly [4];
    bit          spur [4];
    int          mode;

    int          errors = 0;
    int          checks = 0;

    int          m_phase;
    bit          m_fresh;
    logic [3:0]  m_need, m_got, e_starts;
    logic        e_busy, e_done;
    logic [1:0]  e_owner;
    logic [17:0] e_fs_addr, e_ws_addr;
    logic [8:0]  e_fs_stride;
    logic [7:0]  e_ws_stride;
    int          cnt_fs, cnt_ct, cnt_cs, cnt_ws, cnt_done;

    assign fs_done = resp_done[3];
    assign ct_done = resp_done[2];
    assign cs_done = resp_done[1];
    assign ws_done = resp_done[0] | extra_ws;

    always #5 clk = ~clk;

    m2_phase_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .fs_start(fs_start), .ct_start(ct_start), .cs_start(cs_start), .ws_start(ws_start),
        .fs_done(fs_done), .ct_done(ct_done), .cs_done(cs_done), .ws_done(ws_done),
        .fs_base_address(fs_base_address), .fs_row_stride(fs_row_stride),
        .ws_base_address(ws_base_address), .ws_row_stride(ws_row_stride),
        .sram_owner(sram_owner)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Block index -> image geometry, straight from the address formulas.
    function automatic int seg_of(input int b);
        return (b < 1200) ? 0 : ((b < 1800) ? 1 : 2);
    endfunction

    function automatic logic [17:0] fetch_addr(input int b);
        int s, lb, cols, base, rs;
        s    = seg_of(b);
        lb   = b - ((s == 0) ? 0 : ((s == 1) ? 1200 : 1800));
        cols = (s == 0) ? 40 : 20;
        base = (s == 0) ? 76800 : ((s == 1) ? 153600 : 192000);
        rs   = (s == 0) ? 2560 : 1280;
        return 18'(base + (lb / cols) * rs + (lb % cols) * 8);
    endfunction

    function automatic logic [17:0] write_addr(input int b);
        int s, lb, cols, base, rs;
        s    = seg_of(b);
        lb   = b - ((s == 0) ? 0 : ((s == 1) ? 1200 : 1800));
        cols = (s == 0) ? 40 : 20;
        base = (s == 0) ? 0 : ((s == 1) ? 38400 : 57600);
        rs   = (s == 0) ? 1280 : 640;
        return 18'(base + (lb / cols) * rs + (lb % cols) * 4);
    endfunction

    // Phase p of the 4802-phase schedule; engine bits are {FS, CT, CS, WS}.
    function automatic logic [3:0] phase_engines(input int p);
        if (p == 0)    return 4'b1000;
        if (p == 1)    return 4'b0100;
        if (p == 4800) return 4'b0010;
        if (p == 4801) return 4'b0001;
        return ((p % 2) == 0) ? 4'b1010 : 4'b0101;
    endfunction

    function automatic int phase_fs_block(input int p);
        return (p == 0) ? 0 : (p - 2) / 2 + 1;
    endfunction

    function automatic int phase_ws_block(input int p);
        return (p == 4801) ? 2399 : (p - 3) / 2;
    endfunction

    function automatic logic [1:0] phase_owner(input int p);
        if (p == 1 || p == 4800) return 2'd0;
        if (p == 4801)           return 2'd2;
        return ((p % 2) == 0) ? 2'd1 : 2'd2;
    endfunction

    task automatic enterPhase(input int p);
        int b;
        m_phase  = p;
        m_need   = phase_engines(p);
        m_got    = 4'b0;
        m_fresh  = 1'b1;
        e_starts = m_need;
        e_busy   = 1'b1;
        e_owner  = phase_owner(p);
        if (m_need[3]) begin
            b           = phase_fs_block(p);
            e_fs_addr   = fetch_addr(b);
            e_fs_stride = (seg_of(b) == 0) ? 9'd320 : 9'd160;
        end
        if (m_need[0]) begin
            b           = phase_ws_block(p);
            e_ws_addr   = write_addr(b);
            e_ws_stride = (seg_of(b) == 0) ? 8'd160 : 8'd80;
        end
    endtask

    task automatic modelStep();
        e_starts = 4'b0;
        e_done   = 1'b0;
        if (reset) begin
            m_phase = -1; m_fresh = 1'b0; m_need = 4'b0; m_got = 4'b0;
            e_busy = 1'b0; e_owner = 2'd0;
            e_fs_addr = 18'd0; e_fs_stride = 9'd0; e_ws_addr = 18'd0; e_ws_stride = 8'd0;
        end else if (m_phase < 0) begin
            if (start) enterPhase(0);
        end else begin
            if (!m_fresh) m_got = m_got | ({fs_done, ct_done, cs_done, ws_done} & m_need);
            m_fresh = 1'b0;
            if (m_got == m_need) begin
                if (m_phase == 4801) begin
                    m_phase = -1; e_busy = 1'b0; e_done = 1'b1; e_owner = 2'd0;
                end else begin
                    enterPhase(m_phase + 1);
                end
            end
        end
    endtask

    function automatic int pickDelay(input int i);
        case (mode)
            1:       return 3;
            2:       return (i == 3) ? 2 : ((i == 1) ? 7 : 3);
            3:       return 4;
            default: return int'($urandom_range(2, 4));
        endcase
    endfunction

    // Engine responders: answer each start with a done after a chosen delay.
    initial begin
        resp_done  = 4'b0;
        eng_active = 4'b0;
        fin        = 4'b0;
        forever begin
            @(posedge clk);
            eng_active = eng_active & ~fin;
            fin = 4'b0;
            #1;
            st = {fs_start, ct_start, cs_start, ws_start};
            for (int i = 0; i < 4; i++) begin
                if (st[i] === 1'b1) begin
                    eng_active[i] = 1'b1;
                    age[i]  = 0;
                    dly[i]  = pickDelay(i);
                    spur[i] = (mode == 0) && ($urandom_range(0, 5) == 0) && (dly[i] >= 3);
                end
            end
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                nd[i] = 1'b0;
                if (eng_active[i] && !fin[i]) begin
                    age[i]++;
                    if (age[i] == dly[i]) begin
                        nd[i]  = 1'b1;
                        fin[i] = 1'b1;
                    end else if (spur[i] && age[i] == 1) begin
                        nd[i] = 1'b1;
                    end
                end
            end
            resp_done = nd;
        end
    end

    // Cycle-by-cycle comparison against the phase model.
    initial begin
        m_phase = -1;
        forever begin
            @(posedge clk);
            #2;
            modelStep();
            checkOutput("ctrl{starts,busy,done,owner}",
                        {56'd0, fs_start, ct_start, cs_start, ws_start, busy, done, sram_owner},
                        {56'd0, e_starts, e_busy, e_done, e_owner});
            checkOutput("addr{fs_base,fs_stride,ws_base,ws_stride}",
                        {11'd0, fs_base_address, fs_row_stride, ws_base_address, ws_row_stride},
                        {11'd0, e_fs_addr, e_fs_stride, e_ws_addr, e_ws_stride});
            checkOutput("owner_vs_active_engine",
                        {62'd0, (sram_owner == 2'd1) && eng_active[0], (sram_owner == 2'd2) && eng_active[3]},
                        64'd0);
            if (e_starts[3]) begin
                case (phase_fs_block(m_phase))
                    0:    checkOutput("fs_block0",    {fs_base_address, fs_row_stride}, {18'd76800,  9'd320});
                    40:   checkOutput("fs_block40",   {fs_base_address, fs_row_stride}, {18'd79360,  9'd320});
                    1200: checkOutput("fs_block1200", {fs_base_address, fs_row_stride}, {18'd153600, 9'd160});
                    2399: checkOutput("fs_block2399", {fs_base_address, fs_row_stride}, {18'd229272, 9'd160});
                    default: ;
                endcase
            end
            if (e_starts[0]) begin
                case (phase_ws_block(m_phase))
                    0:    checkOutput("ws_block0",    {ws_base_address, ws_row_stride}, {18'd0,     8'd160});
                    40:   checkOutput("ws_block40",   {ws_base_address, ws_row_stride}, {18'd1280,  8'd160});
                    1200: checkOutput("ws_block1200", {ws_base_address, ws_row_stride}, {18'd38400, 8'd80});
                    2399: checkOutput("ws_block2399", {ws_base_address, ws_row_stride}, {18'd76236, 8'd80});
                    default: ;
                endcase
            end
            cnt_fs   += int'(fs_start === 1'b1);
            cnt_ct   += int'(ct_start === 1'b1);
            cnt_cs   += int'(cs_start === 1'b1);
            cnt_ws   += int'(ws_start === 1'b1);
            cnt_done += int'(done === 1'b1);
        end
    end

    task automatic clearCounts();
        cnt_fs = 0; cnt_ct = 0; cnt_cs = 0; cnt_ws = 0; cnt_done = 0;
    endtask

    task automatic finishRun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic applyStimulus();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic waitPhase(input int p);
        int n;
        n = 0;
        while (m_phase < p && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (m_phase < p) begin
            checkOutput("wait_phase_timeout", 64'(m_phase), 64'(p));
            finishRun();
        end
    endtask

    task automatic waitPassEnd();
        int n;
        n = 0;
        while (cnt_done == 0 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (cnt_done == 0) begin
            checkOutput("pass_timeout_done_count", 64'(cnt_done), 64'd1);
            finishRun();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic checkCounts(input int exp_starts, input int exp_done);
        checkOutput("fs_start_count", 64'(cnt_fs),   64'(exp_starts));
        checkOutput("ct_start_count", 64'(cnt_ct),   64'(exp_starts));
        checkOutput("cs_start_count", 64'(cnt_cs),   64'(exp_starts));
        checkOutput("ws_start_count", 64'(cnt_ws),   64'(exp_starts));
        checkOutput("done_count",     64'(cnt_done), 64'(exp_done));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; extra_ws = 1'b0; mode = 1;
        clearCounts();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", {busy, done, sram_owner, fs_base_address, ws_base_address}, 64'd0);

        $display("[TB] pass 1: fixed latency, ordered/simultaneous dones, then random");
        clearCounts();
        applyStimulus();
        waitPhase(20);
        mode = 2;
        waitPhase(40);
        mode = 3;
        waitPhase(60);
        mode = 0;
        waitPhase(500);
        applyStimulus();
        waitPassEnd();
        checkCounts(2400, 1);

        $display("[TB] pass 2: reset during MEGA_B of block 700");
        applyStimulus();
        waitPhase(3 + 2 * 700);
        @(negedge clk) reset = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        clearCounts();
        @(negedge clk) extra_ws = 1'b1;
        @(negedge clk) extra_ws = 1'b0;
        repeat (3) @(negedge clk);
        checkCounts(0, 0);

        $display("[TB] pass 3: full pass after reset");
        clearCounts();
        applyStimulus();
        waitPassEnd();
        checkCounts(2400, 1);

        finishRun();
    end

endmodule
